programmable_clock_divider: RTL
===============================

// Module: programmable_clock_divider
//
// PURPOSE
// Runtime-programmable successor of the fixed-ratio clock divider. Divides clock_in by any integer from 1 to
// 2**DIVISION_WIDTH-1, with exact 50% duty cycle for both even and odd ratios. Ratio changes and enable/disable
// take effect only at output period boundaries, so clock_out never glitches. Sits in clock-generation logic
// feeding peripheral clocks whose frequency is set by software or configuration registers.
//
// PARAMETERS
// DIVISION_WIDTH    8  width of the division value
// DEFAULT_DIVISION  1  ratio loaded at reset; must be 1..2**DIVISION_WIDTH-1
//
// PORTS
// clock_in          in   1               input clock; the only clock (posedge, plus negedge for odd-ratio duty fix)
// reset             in   1               synchronous, active-high reset
// enable            in   1               run request; 0 stops clock_out low at the next period boundary
// division          in   DIVISION_WIDTH  new ratio, sampled when division_load=1
// division_load     in   1               single-cycle request to load division
// clock_out         out  1               divided clock
// period_start      out  1               high for one clock_in cycle starting at each rising edge of clock_out
// update_pending    out  1               loaded ratio not yet applied
// current_division  out  DIVISION_WIDTH  ratio currently generating clock_out
//
// BEHAVIOUR
// - Reset (sampled on posedge clock_in): clock_out=0, period_start=0, update_pending=0, counter=0, stopped,
//   current_division=DEFAULT_DIVISION. Reset mid-period aborts the period at that edge; no runt pulse.
// - Ratio 0 is treated as 1 (stored and reported as 1).
// - States: STOPPED, RUNNING. STOPPED->RUNNING on the first posedge with enable=1 and reset=0; the period
//   starts at that edge (counter=0, clock_out rises). RUNNING->STOPPED at a boundary (posedge where counter
//   would wrap to 0) with enable=0; clock_out stays low from then on. Mid-period deassertion of enable completes
//   the current period.
// - Counter runs 0..N-1 on posedge, N=current_division. Boundary = counter wraps to 0 and period_start=1.
// - Even N: clock_out high for counter < N/2 (N/2 periods high, N/2 low).
// - Odd N>1: posedge term high for counter < (N-1)/2, ORed with a copy of that term re-registered on negedge.
//   High time is exactly N/2 input periods (e.g. N=3: 15ns high, 15ns low at 10ns input period).
// - N=1: clock_out = clock_in gated by a posedge-registered run flag. Switches to or from bypass happen only at a
//   boundary posedge, where both sources are high, so no glitch.
// - division_load=1 at posedge: value captured into a pending register; update_pending=1 from the next cycle.
//   RUNNING: applied at the next boundary; that period uses the new ratio; update_pending clears at that edge.
//   STOPPED: applied at the next posedge.
// - Load while pending: the newer value overwrites the pending one; only the last one is applied.
// - Load on the same posedge as a boundary: the boundary uses the old pending value (if any); the new value waits
//   for the following boundary.
// - current_division changes only at the edge where the ratio is applied.
// - Reset with a load in the same cycle: reset wins; the load is dropped.
//
// TESTING
// - Ratios 1..10 set in turn with enable=1, 10ns clock_in -> measured clock_out frequency = 100MHz/N, 0 if
//   disabled.
// - Duty check for N=2,3,4,7 -> high time = N*5ns exactly. No pulse shorter than 5ns at any point.
// - Load N=4 mid-period while N=6 runs -> current period is 60ns; next period is 40ns; update_pending is high
//   in between; current_division is 6 then 4.
// - Back-to-back loads 3 then 5 within one N=8 period -> next period 50ns; 3 is never applied.
// - enable low mid-period at N=5 -> current 50ns period completes, then clock_out stays 0. Re-enable -> rising
//   edge on the next posedge.
// - Reset asserted mid-high-phase at N=9 -> clock_out=0 after that posedge, current_division=DEFAULT_DIVISION.
//   Switches 1<->3 at a boundary -> no glitch, period_start exactly once per period.

Source files
------------

// File: rtl/programmable_clock_divider.sv
// programmable_clock_divider
//   Divides clock_in by a runtime-programmable ratio N (1 .. 2**DIVISION_WIDTH-1)
//   with a 50% duty cycle for both even and odd N. Ratio changes and
//   enable/disable only take effect at output period boundaries.
//
// Ports
//   clock_in          input clock (posedge logic, one negedge register for odd N)
//   reset             synchronous, active-high
//   enable            run request; deasserting stops clock_out low at the next boundary
//   division          new ratio, captured when division_load is high (0 is stored as 1)
//   division_load     single-cycle load request
//   clock_out         divided clock
//   period_start      high for the clock_in cycle that begins each clock_out period
//   update_pending    a loaded ratio is waiting to be applied
//   current_division  ratio currently generating clock_out
module programmable_clock_divider #(
    parameter int unsigned DIVISION_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIVISION = 1
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DIVISION_WIDTH-1:0] division,
    input  logic                      division_load,
    output logic                      clock_out,
    output logic                      period_start,
    output logic                      update_pending,
    output logic [DIVISION_WIDTH-1:0] current_division
);

    localparam logic [DIVISION_WIDTH-1:0] DIV_ONE     = DIVISION_WIDTH'(1);
    localparam logic [DIVISION_WIDTH-1:0] DEFAULT_DIV = DIVISION_WIDTH'(DEFAULT_DIVISION);

    typedef enum logic {STOPPED, RUNNING} state_t;

    state_t                    state;
    state_t                    next_state;
    logic [DIVISION_WIDTH-1:0] counter;
    logic [DIVISION_WIDTH-1:0] next_count;
    logic [DIVISION_WIDTH-1:0] pend_div;
    logic [DIVISION_WIDTH-1:0] next_div;
    logic [DIVISION_WIDTH-1:0] half_div;
    logic [DIVISION_WIDTH-1:0] load_val;
    logic                      period_end;
    logic                      apply_pend;
    logic                      start_period;
    logic                      run_next;
    logic                      pos_q;
    logic                      pos_d;
    logic                      odd_q;
    logic                      odd_d;
    logic                      byp_q;
    logic                      byp_d;
    logic                      neg_q;

    // State register and posedge datapath.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state            <= STOPPED;
            counter          <= '0;
            current_division <= DEFAULT_DIV;
            pend_div         <= DEFAULT_DIV;
            update_pending   <= 1'b0;
            period_start     <= 1'b0;
            pos_q            <= 1'b0;
            odd_q            <= 1'b0;
            byp_q            <= 1'b0;
        end else begin
            state            <= next_state;
            counter          <= next_count;
            current_division <= next_div;
            period_start     <= start_period;
            pos_q            <= pos_d;
            odd_q            <= odd_d;
            byp_q            <= byp_d;
            if (apply_pend) begin
                update_pending <= 1'b0;
            end
            // A load on a boundary edge is captured after the old pending
            // value has been applied, so it waits for the following boundary.
            if (division_load) begin
                pend_div       <= load_val;
                update_pending <= 1'b1;
            end
        end
    end

    // Half-period copy of the posedge term; only used for odd N > 1.
    always_ff @(negedge clock_in) begin
        neg_q <= pos_q;
    end

    // Next-state logic.
    always_comb begin
        load_val     = (division == '0) ? DIV_ONE : division;
        period_end   = (state == RUNNING) && (counter == current_division - DIV_ONE);
        apply_pend   = update_pending && ((state == STOPPED) || period_end);
        next_div     = apply_pend ? pend_div : current_division;
        start_period = enable && ((state == STOPPED) || period_end);
        next_state   = state;
        unique case (state)
            STOPPED: if (enable)                 next_state = RUNNING;
            RUNNING: if (period_end && !enable)  next_state = STOPPED;
            default:                             next_state = STOPPED;
        endcase
        next_count = ((state == RUNNING) && !period_end) ? counter + DIV_ONE : '0;
    end

    // Output logic. Registered terms are computed for the cycle being entered;
    // half_div is N/2 for even N and (N-1)/2 for odd N.
    always_comb begin
        run_next  = (next_state == RUNNING);
        half_div  = next_div >> 1;
        pos_d     = run_next && (next_div != DIV_ONE) && (next_count < half_div);
        odd_d     = run_next && next_div[0] && (next_div != DIV_ONE);
        byp_d     = run_next && (next_div == DIV_ONE);
        // Bypass and divided sources are only swapped at a boundary posedge,
        // where both are high, so the mux never produces a runt pulse.
        clock_out = (clock_in & byp_q) | pos_q | (odd_q & neg_q);
    end

endmodule
